// File: rtl/viterbi_pkg.sv
// Shared definitions for the hard-decision Viterbi decoder datapath.
//   K, N_STATES   : constraint length and trellis state count
//   W, INIT_PM    : path-metric width and start metric for states other than 0
//   G0, G1        : generator polynomials (c1 uses G0, c0 uses G1)
//   exp_sym()     : expected code symbol {c1,c0} for encoder register r = {u, s}
//   init_pm()     : frame-start metric of a given state
package viterbi_pkg;

    localparam int K        = 3;
    localparam int N_STATES = 2 ** (K - 1);
    localparam int W        = 8;
    localparam int INIT_PM  = 64;

    localparam logic [K-1:0] G0 = 3'o7;
    localparam logic [K-1:0] G1 = 3'o5;

    typedef logic [W-1:0] pm_t;

    function automatic logic [1:0] exp_sym(input logic [K-1:0] r);
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic pm_t init_pm(input int s);
        return (s == 0) ? '0 : pm_t'(INIT_PM);
    endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell, serving a single next-state of the trellis.
//   pm0, pm1 : source path metrics of the predecessors with LSB 0 and LSB 1
//   bm0, bm1 : branch metrics of the two incoming branches
//   pm_new   : survivor metric (low W bits of the winning sum)
//   dec      : 1 when the LSB-1 predecessor survives
//   ovf      : bit W of either sum; must never be set in a working decoder
module acs_cell
    import viterbi_pkg::*;
(
    input  logic [W-1:0] pm0,
    input  logic [W-1:0] pm1,
    input  logic [1:0]   bm0,
    input  logic [1:0]   bm1,
    output logic [W-1:0] pm_new,
    output logic         dec,
    output logic         ovf
);

    logic [W:0] cand0;
    logic [W:0] cand1;

    always_comb begin
        cand0  = {1'b0, pm0} + {{(W-1){1'b0}}, bm0};
        cand1  = {1'b0, pm1} + {{(W-1){1'b0}}, bm1};
        // Strict compare: a tie keeps the LSB-0 predecessor.
        dec    = (cand1 < cand0);
        pm_new = dec ? cand1[W-1:0] : cand0[W-1:0];
        ovf    = cand0[W] | cand1[W];
    end

endmodule

// File: rtl/acs_path_metric_unit.sv
// Add-compare-select / path-metric stage of the hard-decision Viterbi decoder.
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   start       : frame start (re-initialises metrics), qualified by in_valid
//   in_valid    : branch metrics valid this cycle
//   bm          : bm[2e+1:2e] = Hamming distance of the rx pair to symbol e
//   out_valid   : in_valid delayed by one cycle
//   dec         : survivor bit per next-state (1 = predecessor with LSB 1)
//   best_state  : index of the minimum path metric (ties -> lowest index)
//   best_metric : value of the minimum path metric
module acs_path_metric_unit
    import viterbi_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          bm,
    output logic                out_valid,
    output logic [N_STATES-1:0] dec,
    output logic [K-2:0]        best_state,
    output logic [W-1:0]        best_metric
);

    pm_t                 pm_q      [N_STATES];
    pm_t                 pm_d      [N_STATES];
    pm_t                 pm_src    [N_STATES];
    pm_t                 pm_acs    [N_STATES];
    pm_t                 pm_norm   [N_STATES];
    logic [N_STATES-1:0] dec_acs;
    logic [N_STATES-1:0] ovf_acs;
    logic [N_STATES-1:0] dec_q, dec_d;
    logic [K-2:0]        best_state_q, best_state_d;
    pm_t                 best_metric_q, best_metric_d;
    logic                out_valid_q, out_valid_d;
    logic                all_msb;
    logic [K-2:0]        min_idx;
    pm_t                 min_val;

    // A start symbol runs its ACS on the init metrics instead of the registers.
    always_comb begin
        for (int s = 0; s < N_STATES; s++) begin
            pm_src[s] = start ? init_pm(s) : pm_q[s];
        end
    end

    // Next-state n is reached from encoder registers {n,0} and {n,1};
    // the predecessor state is the low K-1 bits of that register.
    for (genvar n = 0; n < N_STATES; n++) begin : g_acs
        localparam logic [K-1:0] R0 = K'(2 * n);
        localparam logic [K-1:0] R1 = K'(2 * n + 1);
        localparam int           E0 = int'(exp_sym(R0));
        localparam int           E1 = int'(exp_sym(R1));

        acs_cell u_acs_cell (
            .pm0    (pm_src[R0[K-2:0]]),
            .pm1    (pm_src[R1[K-2:0]]),
            .bm0    (bm[2*E0 +: 2]),
            .bm1    (bm[2*E1 +: 2]),
            .pm_new (pm_acs[n]),
            .dec    (dec_acs[n]),
            .ovf    (ovf_acs[n])
        );
    end

    // Metrics stay within a small spread of each other, so dropping the MSB
    // when every metric has it set preserves all differences (modulo norm).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        all_msb = 1'b1;
        for (int n = 0; n < N_STATES; n++) begin
            all_msb &= pm_acs[n][W-1];
        end
        for (int n = 0; n < N_STATES; n++) begin
            pm_norm[n] = pm_acs[n];
            if (all_msb) begin
                pm_norm[n][W-1] = 1'b0;
            end
        end

        // Strict '<' while scanning upward resolves ties to the lowest index.
        min_idx = '0;
        min_val = pm_norm[0];
        for (int n = 1; n < N_STATES; n++) begin
            if (pm_norm[n] < min_val) begin
                min_idx = (K-1)'(n);
                min_val = pm_norm[n];
            end
        end
    end

    always_comb begin
        pm_d          = pm_q;
        dec_d         = dec_q;
        best_state_d  = best_state_q;
        best_metric_d = best_metric_q;
        out_valid_d   = in_valid;
        if (in_valid) begin
            pm_d          = pm_norm;
            dec_d         = dec_acs;
            best_state_d  = min_idx;
            best_metric_d = min_val;
        end
    end

    always_comb begin
        if (rst_n && in_valid) begin
            assert (ovf_acs == '0);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the metric array is reset because decoding starts from defined metrics, not just a flag.
            for (int s = 0; s < N_STATES; s++) begin
                pm_q[s] <= init_pm(s);
            end
            dec_q         <= '0;
            best_state_q  <= '0;
            best_metric_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            pm_q          <= pm_d;
            dec_q         <= dec_d;
            best_state_q  <= best_state_d;
            best_metric_q <= best_metric_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign dec         = dec_q;
    assign best_state  = best_state_q;
    assign best_metric = best_metric_q;

endmodule

// File: tb/tb_acs_path_metric_unit.sv
// Self-checking bench for acs_path_metric_unit: directed trellis scenarios,
// normalization, gaps, mid-stream reset, then randomized symbol streams,
// all compared against a behavioural Viterbi metric model.
module tb_acs_path_metric_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] bm;
    logic       out_valid;
    logic [3:0] dec;
    logic [1:0] best_state;
    logic [7:0] best_metric;

    always #5 clk = ~clk;

    acs_path_metric_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .bm          (bm),
        .out_valid   (out_valid),
        .dec         (dec),
        .best_state  (best_state),
        .best_metric (best_metric)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int pm_m [4];
    int dec_m;
    int bs_m;
    int bmet_m;
    int ov_m;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bm_of(input int rx);
        logic [7:0] v;
        v = '0;
        for (int e = 0; e < 4; e++) begin
            v[2*e +: 2] = 2'($countones(2'(e ^ rx)));
        end
        return v;
    endfunction

    task automatic model_reset();
        pm_m   = '{0, 64, 64, 64};
        dec_m  = 0;
        bs_m   = 0;
        bmet_m = 0;
        ov_m   = 0;
    endtask

    // Behavioural Viterbi step: next state n = {u, s1}; its predecessor is
    // {s1, b}; the encoder emits c1 = u^s1^b, c0 = u^b.
    task automatic model_beat(input bit st, input bit v, input logic [7:0] b);
        int src [4];
        int nw  [4];
        int u, s1, c1, c0, sym, d, cand, mn;
        ov_m = v;
        if (!v) return;
        for (int s = 0; s < 4; s++) src[s] = st ? ((s == 0) ? 0 : 64) : pm_m[s];
        dec_m = 0;
        for (int n = 0; n < 4; n++) begin
            u  = (n >> 1) & 1;
            s1 = n & 1;
            for (int bb = 0; bb < 2; bb++) begin
                c1   = u ^ s1 ^ bb;
                c0   = u ^ bb;
                sym  = c1 * 2 + c0;
                d    = (b >> (2 * sym)) & 3;
                cand = src[s1 * 2 + bb] + d;
                if (bb == 0) nw[n] = cand;
                else if (cand < nw[n]) begin
                    nw[n] = cand;
                    dec_m |= (1 << n);
                end
            end
        end
        mn = nw[0];
        for (int n = 1; n < 4; n++) if (nw[n] < mn) mn = nw[n];
        if (mn >= 128) for (int n = 0; n < 4; n++) nw[n] -= 128;
        pm_m = nw;
        bs_m = 0;
        for (int n = 3; n >= 0; n--) if (pm_m[n] <= pm_m[bs_m]) bs_m = n;
        bmet_m = pm_m[bs_m];
    endtask

    task automatic compare(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), ov_m);
        check({tag, "_dec"}, int'(dec), dec_m);
        check({tag, "_best_state"}, int'(best_state), bs_m);
        check({tag, "_best_metric"}, int'(best_metric), bmet_m);
    endtask

    task automatic beat(input string tag, input bit st, input bit v, input logic [7:0] b);
        @(negedge clk);
        start    = st;
        in_valid = v;
        bm       = b;
        @(posedge clk);
        model_beat(st, v, b);
        #1;
        compare(tag);
    endtask

    // Reset asserted together with start/in_valid: reset must win.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        bm       = 8'hFF;
        @(posedge clk);
        model_reset();
        #1;
        compare(tag);
        @(negedge clk);
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    int rx_seq3 [4] = '{3, 2, 0, 1};
    int rx_seq4 [4] = '{3, 3, 0, 1};
    int prev_best;
    bit norm_seen;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        bm       = '0;
        model_reset();

        // 1. reset state; a non-start beat then exposes the init metrics
        do_reset("t1_reset");
        beat("t1_init", 1'b0, 1'b1, bm_of(0));

        // 2. start + rx 00
        beat("t2", 1'b1, 1'b1, bm_of(0));
        check("t2_dec0", int'(dec[0]), 0);
        check("t2_best_state", int'(best_state), 0);
        check("t2_best_metric", int'(best_metric), 0);

        // 3. error-free stream for input bits 1,0,1,1
        for (int i = 0; i < 4; i++) beat("t3", i == 0, 1'b1, bm_of(rx_seq3[i]));
        check("t3_final_metric", int'(best_metric), 0);
        check("t3_final_state", int'(best_state), 3);

        // 4. one flipped rx bit on beat 2
        for (int i = 0; i < 4; i++) beat("t4", i == 0, 1'b1, bm_of(rx_seq4[i]));
        check("t4_final_metric", int'(best_metric), 1);
        check("t4_final_state", int'(best_state), 3);

        // 5. normalization with every branch metric = 2
        norm_seen = 1'b0;
        beat("t5", 1'b1, 1'b1, 8'hAA);
        prev_best = int'(best_metric);
        for (int i = 1; i < 72; i++) begin
            beat("t5", 1'b0, 1'b1, 8'hAA);
            if (int'(best_metric) < prev_best) norm_seen = 1'b1;
            prev_best = int'(best_metric);
        end
        check("t5_norm_seen", int'(norm_seen), 1);

        // 6. gaps, then mid-stream reset
        beat("t6_pre", 1'b1, 1'b1, bm_of(2));
        beat("t6_pre", 1'b0, 1'b1, bm_of(1));
        for (int i = 0; i < 3; i++) beat("t6_gap", 1'b0, 1'b0, bm_of(3));
        beat("t6_post", 1'b0, 1'b1, bm_of(3));
        do_reset("t6_reset");
        beat("t6_after_reset", 1'b0, 1'b1, bm_of(1));

        // Randomized streams with gaps, restarts and channel errors
        for (int i = 0; i < 600; i++) begin
            int  rx;
            bit  v, st;
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 39) == 0);
            rx = int'($urandom_range(0, 3));
            beat("rand", st, v, bm_of(rx));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
